// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared types and constants for the elevator input conditioner.
//   deb_state_e        : per-channel debounce FSM state
//   NUM_FLOORS         : floors served (one request channel per floor and kind)
//   STUCK_*_LSB        : base bit of each request group inside the stuck vector
// Optional feature macro used by the importing files: ELEV_STUCK_DETECT_EN.
// -----------------------------------------------------------------------------
package elevator_pkg;

    localparam int unsigned NUM_FLOORS       = 4;
    localparam int unsigned NUM_REQ_CHANNELS = 3 * NUM_FLOORS;

    localparam int unsigned STUCK_CABIN_LSB  = 0;
    localparam int unsigned STUCK_EXT_UP_LSB = 4;
    localparam int unsigned STUCK_EXT_DN_LSB = 8;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } deb_state_e;

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One conditioned input: synchronizer chain, 4-state debounce FSM with a
// saturating stability counter, rising-edge request pulse and (when the build
// defines ELEV_STUCK_DETECT_EN) a stuck-high detector.
// Ports:
//   clk_i    : system clock
//   rst_i    : asynchronous active-high reset
//   raw_i    : raw switch level (polarity given by RAW_IDLE)
//   level_o  : debounced active-high level
//   pulse_o  : one-cycle pulse the cycle after level_o rises
//   stuck_o  : level has been high too long (0 when detection is not built)
// Parameters:
//   RAW_IDLE    : inactive raw level; 1 marks an active-low input
//   FAST_ATTACK : accept a high sample at once, debounce only the release
// -----------------------------------------------------------------------------
module debounce_channel
    import elevator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter bit          RAW_IDLE        = 1'b0,
    parameter bit          FAST_ATTACK     = 1'b0
`ifdef ELEV_STUCK_DETECT_EN
    ,
    parameter int unsigned STUCK_CYCLES    = 500000000,
    parameter bit          STUCK_EN        = 1'b0
`endif
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic pulse_o,
    output logic stuck_o
);

    localparam int unsigned      CNT_W         = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Counter value on the sample that completes the stable run.
    localparam logic [CNT_W-1:0] CNT_LAST_PEND = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    deb_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   level_prev_q;
    logic                   pulse_q;
    logic                   stuck_flag;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RAW_IDLE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Internal polarity is always active-high.
    assign sample = sync_q[SYNC_STAGES-1] ^ RAW_IDLE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= STABLE_LO;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            level_prev_q <= level_q;
            pulse_q      <= level_q & ~level_prev_q & ~stuck_flag;
            unique case (state_q)
                STABLE_LO: begin
                    if (sample) begin
                        cnt_q <= '0;
                        if (FAST_ATTACK) begin
                            state_q <= STABLE_HI;
                            level_q <= 1'b1;
                        end else begin
                            state_q <= PEND_HI;
                        end
                    end
                end
                PEND_HI: begin
                    if (!sample) begin
                        state_q <= STABLE_LO;
                    end else if (cnt_q == CNT_LAST_PEND) begin
                        cnt_q   <= CNT_MAX;
                        state_q <= STABLE_HI;
                        level_q <= 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!sample) begin
                        cnt_q   <= '0;
                        state_q <= PEND_LO;
                    end
                end
                PEND_LO: begin
                    if (sample) begin
                        state_q <= STABLE_HI;
                    end else if (cnt_q == CNT_LAST_PEND) begin
                        cnt_q   <= CNT_MAX;
                        state_q <= STABLE_LO;
                        level_q <= 1'b0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= STABLE_LO;
                end
            endcase
        end
    end

`ifdef ELEV_STUCK_DETECT_EN
    if (STUCK_EN) begin : g_stuck
        localparam int unsigned       SCNT_W    = $clog2(STUCK_CYCLES);
        localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STUCK_CYCLES - 1);

        logic [SCNT_W-1:0] scnt_q;
        logic              stuck_q;
        logic              fall_now;

        // Debounced level drops at this edge; clear in the same cycle it falls.
        assign fall_now = (state_q == PEND_LO) && !sample && (cnt_q == CNT_LAST_PEND);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                scnt_q  <= '0;
                stuck_q <= 1'b0;
            end else if (!level_q || fall_now) begin
                scnt_q  <= '0;
                stuck_q <= 1'b0;
            end else if (scnt_q == SCNT_LAST) begin
                stuck_q <= 1'b1;
            end else begin
                scnt_q <= scnt_q + 1'b1;
            end
        end

        assign stuck_flag = stuck_q;
    end else begin : g_no_stuck
        assign stuck_flag = 1'b0;
    end
`else
    assign stuck_flag = 1'b0;
`endif

    // Fast-attack channels follow the synchronized sample directly on assertion.
    assign level_o = FAST_ATTACK ? (level_q | sample) : level_q;
    assign pulse_o = pulse_q;
    assign stuck_o = stuck_flag;

endmodule

// File: rtl/elevator_input_conditioner.sv
// -----------------------------------------------------------------------------
// elevator_input_conditioner
// Synchronizes and debounces the 15 raw elevator inputs.
// Ports:
//   CLOCK_50                   : 50 MHz system clock
//   reset                      : asynchronous active-high reset
//   cabin_key_n[3:0]           : raw cabin buttons, active-low, bit i = floor i
//   ext_up_sw/ext_dn_sw[3:0]   : raw hall-call switches, active-high
//   emergency_sw/overload_sw/door_hold_sw : raw control switches, active-high
//   cabin_req/ext_up_req/ext_dn_req[3:0]  : one-cycle request pulses per floor
//   emergency/overload/door_hold          : conditioned levels
//   stuck[11:0]                : stuck flags, [3:0] cabin, [7:4] up, [11:8] down
// Build option: define ELEV_STUCK_DETECT_EN to build stuck detection; otherwise
// stuck is constant 0 and pulses are never suppressed.
// -----------------------------------------------------------------------------
module elevator_input_conditioner
    import elevator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned STUCK_CYCLES    = 500000000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [3:0]  cabin_key_n,
    input  logic [3:0]  ext_up_sw,
    input  logic [3:0]  ext_dn_sw,
    input  logic        emergency_sw,
    input  logic        overload_sw,
    input  logic        door_hold_sw,
    output logic [3:0]  cabin_req,
    output logic [3:0]  ext_up_req,
    output logic [3:0]  ext_dn_req,
    output logic        emergency,
    output logic        overload,
    output logic        door_hold,
    output logic [11:0] stuck
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'h00FF_FFFF ||
        SYNC_STAGES < 2 || SYNC_STAGES > 4 || STUCK_CYCLES < 2) begin : g_bad_params
        $error("elevator_input_conditioner: parameter out of legal range");
    end

    logic [NUM_REQ_CHANNELS-1:0] req_raw;
    logic [NUM_REQ_CHANNELS-1:0] req_pulse;
    logic [NUM_REQ_CHANNELS-1:0] req_level;
    logic [NUM_REQ_CHANNELS-1:0] req_stuck;
    logic [2:0]                  ctl_raw;
    logic [2:0]                  ctl_level;
    logic [2:0]                  ctl_pulse;
    logic [2:0]                  ctl_stuck;
    logic                        unused_chan_outputs;

    assign req_raw = {ext_dn_sw, ext_up_sw, cabin_key_n};
    assign ctl_raw = {door_hold_sw, overload_sw, emergency_sw};

    for (genvar i = 0; i < NUM_REQ_CHANNELS; i++) begin : g_req
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .RAW_IDLE        (i < NUM_FLOORS),
            .FAST_ATTACK     (1'b0)
`ifdef ELEV_STUCK_DETECT_EN
            ,
            .STUCK_CYCLES    (STUCK_CYCLES),
            .STUCK_EN        (1'b1)
`endif
        ) u_chan (
            .clk_i   (CLOCK_50),
            .rst_i   (reset),
            .raw_i   (req_raw[i]),
            .level_o (req_level[i]),
            .pulse_o (req_pulse[i]),
            .stuck_o (req_stuck[i])
        );
    end

    // Bit 0 is emergency: asserts on the first high sample, debounced on release.
    for (genvar i = 0; i < 3; i++) begin : g_ctl
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .RAW_IDLE        (1'b0),
            .FAST_ATTACK     (i == 0)
`ifdef ELEV_STUCK_DETECT_EN
            ,
            .STUCK_CYCLES    (STUCK_CYCLES),
            .STUCK_EN        (1'b0)
`endif
        ) u_chan (
            .clk_i   (CLOCK_50),
            .rst_i   (reset),
            .raw_i   (ctl_raw[i]),
            .level_o (ctl_level[i]),
            .pulse_o (ctl_pulse[i]),
            .stuck_o (ctl_stuck[i])
        );
    end

    assign cabin_req  = req_pulse[STUCK_CABIN_LSB  +: NUM_FLOORS];
    assign ext_up_req = req_pulse[STUCK_EXT_UP_LSB +: NUM_FLOORS];
    assign ext_dn_req = req_pulse[STUCK_EXT_DN_LSB +: NUM_FLOORS];
    assign stuck      = req_stuck;

    assign emergency  = ctl_level[0];
    assign overload   = ctl_level[1];
    assign door_hold  = ctl_level[2];

    // Request levels and control pulses/stuck flags have no consumer.
    assign unused_chan_outputs = ^{req_level, ctl_pulse, ctl_stuck};

endmodule
